// File: rtl/pla_bist_pkg.sv
// pla_bist_pkg
// Shared definitions for the PLA BIST controller: FSM state encoding, the
// stimulus LFSR polynomial and the response MISR polynomial. Tap positions
// are 1-based polynomial exponents. The masks select the register bits that
// feed the XOR.
package pla_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_t;

   localparam int LFSR_W = 26;
   localparam int MISR_W = 10;

   localparam int LFSR_TAP_0 = 26;
   localparam int LFSR_TAP_1 = 6;
   localparam int LFSR_TAP_2 = 2;
   localparam int LFSR_TAP_3 = 1;

   localparam int MISR_TAP_0 = 10;
   localparam int MISR_TAP_1 = 7;

   localparam logic [LFSR_W-1:0] LFSR_MASK = (LFSR_W'(1) << (LFSR_TAP_0 - 1))
                                           | (LFSR_W'(1) << (LFSR_TAP_1 - 1))
                                           | (LFSR_W'(1) << (LFSR_TAP_2 - 1))
                                           | (LFSR_W'(1) << (LFSR_TAP_3 - 1));

   localparam logic [MISR_W-1:0] MISR_MASK = (MISR_W'(1) << (MISR_TAP_0 - 1))
                                           | (MISR_W'(1) << (MISR_TAP_1 - 1));

   // Shift left and insert the parity of the tapped bits at bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], ^(l & LFSR_MASK)};
   endfunction

endpackage

// File: rtl/pla_misr.sv
// pla_misr
// Multiple-input signature register. It shifts toward the MSB and folds the
// tapped bits back into bit 0, XORing the parallel input d into every stage.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the signature
//   clr  : synchronous clear, used when a new run starts
//   en   : capture d this cycle
//   d    : parallel response input
//   q    : current signature
module pla_misr
   import pla_bist_pkg::*;
#(
   parameter int               WIDTH = MISR_W,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(MISR_MASK)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_next;

   always_comb begin
      q_next = {q[WIDTH-2:0], ^(q & TAPS)} ^ d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= q_next;
      end
   end

endmodule

// File: rtl/pla_in7_bist.sv
// pla_in7_bist
// Built-in self test for a 26-input / 10-output PLA. An LFSR drives
// NUM_PATTERNS vectors onto x_out. The PLA response z_in comes back RESP_LAT
// cycles later and is compressed in a MISR. At the end the signature is
// compared with GOLDEN_SIG.
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   start         : run request, honoured only in IDLE or DONE
//   x_out[25:0]   : registered stimulus vector to the PLA
//   z_in[9:0]     : PLA response
//   busy          : run in progress (RUN or DRAIN)
//   done          : run finished (level)
//   pass          : in DONE, signature matches GOLDEN_SIG
//   signature     : current MISR contents
//   pattern_count : vectors applied in the current or last run
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, x_out = 0, waiting for start
// RUN   | one LFSR vector applied per cycle, NUM_PATTERNS cycles
// DRAIN | RESP_LAT cycles collecting the last in-flight responses
// DONE  | results held until the next start or reset
module pla_in7_bist
   import pla_bist_pkg::*;
#(
   parameter int                NUM_PATTERNS = 1024,
   parameter logic [LFSR_W-1:0] SEED         = 26'h0000001,
   parameter int                RESP_LAT     = 0,
   parameter logic [MISR_W-1:0] GOLDEN_SIG   = 10'h000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [LFSR_W-1:0] x_out,
   input  logic [MISR_W-1:0] z_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [MISR_W-1:0] signature,
   output logic [15:0]       pattern_count
);

   // An all-zero seed would lock the LFSR at zero.
   localparam logic [LFSR_W-1:0] SEED_EFF   = (SEED == '0) ? LFSR_W'(1) : SEED;
   localparam logic [15:0]       NUM_PAT_W  = 16'(NUM_PATTERNS);
   localparam logic [15:0]       LAST_IDX   = 16'(NUM_PATTERNS - 1);
   localparam logic [1:0]        DRAIN_LOAD = (RESP_LAT > 0) ? 2'(RESP_LAT - 1) : 2'd0;

   bist_state_t       state_q;
   bist_state_t       state_d;
   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] x_q;
   logic [15:0]       pcount_q;
   logic [1:0]        drain_cnt_q;

   logic start_load;
   logic last_vec;
   logic drain_tc;
   logic tok;
   logic sample;

   assign start_load = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
   assign last_vec   = (state_q == ST_RUN) && (pcount_q == LAST_IDX);
   assign drain_tc   = (drain_cnt_q == 2'd0);
   // Every RUN cycle presents one vector and launches one valid token.
   assign tok        = (state_q == ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (last_vec) state_d = (RESP_LAT > 0) ? ST_DRAIN : ST_DONE;
         end
         ST_DRAIN: begin
            if (drain_tc) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // x_q tracks the LFSR everywhere except IDLE, where it reads zero. After the
   // last vector both registers hold, so DRAIN and DONE show that vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q      <= SEED_EFF;
         x_q         <= '0;
         pcount_q    <= '0;
         drain_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  lfsr_q   <= SEED_EFF;
                  x_q      <= SEED_EFF;
                  pcount_q <= '0;
               end
            end
            ST_RUN: begin
               if (pcount_q != NUM_PAT_W) pcount_q <= pcount_q + 16'd1;
               if (last_vec) begin
                  drain_cnt_q <= DRAIN_LOAD;
               end else begin
                  lfsr_q <= lfsr_step(lfsr_q);
                  x_q    <= lfsr_step(lfsr_q);
               end
            end
            ST_DRAIN: begin
               if (!drain_tc) drain_cnt_q <= drain_cnt_q - 2'd1;
            end
            default: ;
         endcase
      end
   end

   // The valid pipe delays each token to the cycle its response is on z_in.
   generate
      if (RESP_LAT == 0) begin : g_nolat
         assign sample = tok;
      end else begin : g_lat
         logic [RESP_LAT-1:0] vpipe_q;
         always_ff @(posedge clk) begin
            if (rst || start_load) begin
               vpipe_q <= '0;
            end else begin
               vpipe_q[0] <= tok;
               for (int i = 1; i < RESP_LAT; i++) vpipe_q[i] <= vpipe_q[i-1];
            end
         end
         assign sample = vpipe_q[RESP_LAT-1];
      end
   endgenerate

   pla_misr #(
      .WIDTH (MISR_W),
      .TAPS  (MISR_MASK)
   ) u_misr (
      .clk (clk),
      .rst (rst),
      .clr (start_load),
      .en  (sample),
      .d   (z_in),
      .q   (signature)
   );

   assign x_out         = x_q;
   assign pattern_count = pcount_q;
   assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done          = (state_q == ST_DONE);
   assign pass          = (state_q == ST_DONE) && (signature == GOLDEN_SIG);

endmodule
